// File: rtl/ct_spsram_2048x32_arb.sv
// Round-robin two-requester arbiter and access sequencer for one 2048x32 single-port SRAM.
// Define CT_SPSRAM_ARB_INIT_EN to zero-fill the whole array after reset before granting requests.
module ct_spsram_2048x32_arb #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,

    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [BE_WIDTH-1:0]   req0_be,
    output logic                  req0_gnt,
    output logic                  req0_rvld,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [BE_WIDTH-1:0]   req1_be,
    output logic                  req1_gnt,
    output logic                  req1_rvld,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic                  init_done,

    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  arb_live;
    logic                  init_active;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rr_ptr_q;
    logic                  win_wr;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [BE_WIDTH-1:0]   win_be;
    logic                  win_access;
    logic [ADDR_WIDTH-1:0] a_hold_q;
    logic [DATA_WIDTH-1:0] d_hold_q;
    logic                  rvld0_q;
    logic                  rvld1_q;

`ifdef CT_SPSRAM_ARB_INIT_EN
    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] init_cnt_d;
    logic                  init_done_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= (state_d == ST_IDLE);
        end
    end

    // The counter wraps to zero on the write to the last entry, which is also the exit condition.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_active = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_active = cpurst_b;
                init_cnt_d  = init_cnt_q + 1'b1;
                if (&init_cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign arb_live  = cpurst_b && (state_q == ST_IDLE);
    assign init_done = init_done_q;
`else
    assign init_active = 1'b0;
    assign arb_live    = cpurst_b;
    assign init_done   = 1'b1;
`endif

    // rr_ptr only breaks ties; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_live) begin
            if (req0_vld && req1_vld) begin
                gnt0 = ~rr_ptr_q;
                gnt1 = rr_ptr_q;
            end else begin
                gnt0 = req0_vld;
                gnt1 = req1_vld;
            end
        end
    end

    assign req0_gnt = gnt0;
    assign req1_gnt = gnt1;

    assign win_wr    = gnt1 ? req1_wr    : req0_wr;
    assign win_addr  = gnt1 ? req1_addr  : req0_addr;
    assign win_wdata = gnt1 ? req1_wdata : req0_wdata;
    assign win_be    = gnt1 ? req1_be    : req0_be;

    // A write with no byte enabled is accepted but never reaches the array.
    assign win_access = (gnt0 || gnt1) && (!win_wr || (|win_be));

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_ptr_q <= 1'b0;
        end else if (gnt0 || gnt1) begin
            rr_ptr_q <= gnt0;
        end
    end

    // Address and data hold their last value when idle so the SRAM pins do not toggle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_hold_q;
        sram_d    = d_hold_q;
        if (init_active) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_d    = '0;
`ifdef CT_SPSRAM_ARB_INIT_EN
            sram_a    = init_cnt_q;
`endif
        end else if (win_access) begin
            sram_cen = 1'b0;
            sram_a   = win_addr;
            if (win_wr) begin
                sram_gwen = 1'b0;
                sram_d    = win_wdata;
                for (int k = 0; k < BE_WIDTH; k++) begin
                    sram_wen[8*k +: 8] = {8{~win_be[k]}};
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            a_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            a_hold_q <= sram_a;
            d_hold_q <= sram_d;
        end
    end

    // SRAM Q is valid the cycle after the access, so only the valid flag is registered.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rvld0_q <= 1'b0;
            rvld1_q <= 1'b0;
        end else begin
            rvld0_q <= gnt0 && !req0_wr;
            rvld1_q <= gnt1 && !req1_wr;
        end
    end

    assign req0_rvld  = rvld0_q;
    assign req1_rvld  = rvld1_q;
    assign req0_rdata = rvld0_q ? sram_q : '0;
    assign req1_rdata = rvld1_q ? sram_q : '0;

endmodule

// File: tb/tb_ct_spsram_2048x32_arb.sv
// Self-checking bench for ct_spsram_2048x32_arb: bench-side SRAM, abstract reference model, directed and random traffic.
// Follows CT_SPSRAM_ARB_INIT_EN the same way the design does.
`timescale 1ns/1ps
module tb_ct_spsram_2048x32_arb;

`ifdef CT_SPSRAM_ARB_INIT_EN
    localparam bit HAS_INIT = 1'b1;
`else
    localparam bit HAS_INIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  vld;
    logic [1:0]  wr;
    logic [10:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        gnt0, gnt1, rvld0, rvld1;
    logic [1:0]  gnt_vec;
    logic [1:0]  rvld_vec;
    logic [31:0] rdata_vec [2];
    logic        init_done;
    logic [10:0] sram_a;
    logic        sram_cen, sram_gwen;
    logic [31:0] sram_wen, sram_d, sram_q;

    logic [31:0] sram_mem [2048];
    logic [31:0] ref_mem  [2048];
    logic [31:0] pat_7ff;

    int          cmp_count  = 0;
    int          fail_count = 0;

    int          favor;
    bit          pend_v [2];
    logic [31:0] pend_d [2];
    bit          in_init;
    int          init_cnt;
    int          m_w;
    logic [31:0] m_mask;

    always #5 clk = ~clk;

    assign gnt_vec  = {gnt1, gnt0};
    assign rvld_vec = {rvld1, rvld0};

    ct_spsram_2048x32_arb dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .req0_vld       (vld[0]),
        .req0_wr        (wr[0]),
        .req0_addr      (addr[0]),
        .req0_wdata     (wdata[0]),
        .req0_be        (be[0]),
        .req0_gnt       (gnt0),
        .req0_rvld      (rvld0),
        .req0_rdata     (rdata_vec[0]),
        .req1_vld       (vld[1]),
        .req1_wr        (wr[1]),
        .req1_addr      (addr[1]),
        .req1_wdata     (wdata[1]),
        .req1_be        (be[1]),
        .req1_gnt       (gnt1),
        .req1_rvld      (rvld1),
        .req1_rdata     (rdata_vec[1]),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // Bench-side single-port SRAM: bit-masked write, Q registered one cycle after a read.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= sram_mem[sram_a];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated once per cycle at the falling edge, then advanced as the next rising edge will.
    always @(negedge clk) begin
        if (!rst_n) begin
            favor    = 0;
            pend_v   = '{1'b0, 1'b0};
            in_init  = HAS_INIT;
            init_cnt = 0;
            checkOutput("rst_gnt",  {30'd0, gnt_vec}, 32'd0);
            checkOutput("rst_rvld", {30'd0, rvld_vec}, 32'd0);
            checkOutput("rst_cen",  sram_cen, 32'd1);
            checkOutput("rst_gwen", sram_gwen, 32'd1);
            checkOutput("rst_wen",  sram_wen, 32'hFFFF_FFFF);
            checkOutput("rst_init_done", init_done, HAS_INIT ? 32'd0 : 32'd1);
        end else begin
            for (int r = 0; r < 2; r++) begin
                checkOutput($sformatf("rvld%0d", r), rvld_vec[r], pend_v[r]);
                checkOutput($sformatf("rdata%0d", r), rdata_vec[r], pend_v[r] ? pend_d[r] : 32'd0);
                pend_v[r] = 1'b0;
            end
            if (in_init) begin
                checkOutput("init_done_low", init_done, 32'd0);
                checkOutput("init_gnt",  {30'd0, gnt_vec}, 32'd0);
                checkOutput("init_cen",  sram_cen, 32'd0);
                checkOutput("init_gwen", sram_gwen, 32'd0);
                checkOutput("init_wen",  sram_wen, 32'd0);
                checkOutput("init_d",    sram_d, 32'd0);
                checkOutput("init_a",    {21'd0, sram_a}, init_cnt);
                ref_mem[init_cnt] = 32'd0;
                init_cnt++;
                if (init_cnt == 2048) in_init = 1'b0;
            end else begin
                checkOutput("init_done_high", init_done, 32'd1);
                m_w = -1;
                if (vld[0] && vld[1]) m_w = favor;
                else if (vld[0]) m_w = 0;
                else if (vld[1]) m_w = 1;
                checkOutput("gnt0", gnt0, (m_w == 0));
                checkOutput("gnt1", gnt1, (m_w == 1));
                if (m_w >= 0 && (!wr[m_w] || be[m_w] != 4'd0)) begin
                    checkOutput("acc_cen", sram_cen, 32'd0);
                    checkOutput("acc_a", {21'd0, sram_a}, {21'd0, addr[m_w]});
                    if (wr[m_w]) begin
                        for (int k = 0; k < 4; k++) m_mask[8*k +: 8] = {8{be[m_w][k]}};
                        checkOutput("wr_gwen", sram_gwen, 32'd0);
                        checkOutput("wr_wen",  sram_wen, ~m_mask);
                        checkOutput("wr_d",    sram_d, wdata[m_w]);
                        ref_mem[addr[m_w]] = (ref_mem[addr[m_w]] & ~m_mask) | (wdata[m_w] & m_mask);
                    end else begin
                        checkOutput("rd_gwen", sram_gwen, 32'd1);
                        pend_v[m_w] = 1'b1;
                        pend_d[m_w] = ref_mem[addr[m_w]];
                    end
                end else begin
                    checkOutput("idle_cen",  sram_cen, 32'd1);
                    checkOutput("idle_gwen", sram_gwen, 32'd1);
                    checkOutput("idle_wen",  sram_wen, 32'hFFFF_FFFF);
                end
                if (m_w >= 0) favor = (m_w == 0) ? 1 : 0;
            end
        end
    end

    // Drive one request on requester r, hold it until granted, and collect what the grant cycle and read return show.
    task automatic applyStimulus(input int r, input bit w_en, input logic [10:0] a, input logic [31:0] d,
                                 input logic [3:0] b, output logic [31:0] rd, output logic [31:0] wen_seen,
                                 output logic cen_seen, output int waited);
        bit done;
        wr[r] = w_en; addr[r] = a; wdata[r] = d; be[r] = b; vld[r] = 1'b1;
        waited = 0; done = 1'b0; rd = 32'd0; wen_seen = 32'd0; cen_seen = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (gnt_vec[r]) begin
                done = 1'b1;
                wen_seen = sram_wen;
                cen_seen = sram_cen;
            end else begin
                waited++;
                if (waited > 3000) begin
                    checkOutput("grant_timeout", waited, 32'd0);
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        vld[r] = 1'b0;
        if (!w_en) begin
            @(negedge clk);
            rd = rdata_vec[r];
            checkOutput("rvld_after_gnt", rvld_vec[r], 32'd1);
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rd, ws;
    logic        cs;
    int          waited;
    int          n, cyc, prev;
    logic [1:0]  gseen;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        pat_7ff = ref_mem[11'h7FF];
        sram_q = 32'd0;
        vld = 2'b00; wr = 2'b00;
        for (int r = 0; r < 2; r++) begin
            addr[r] = 11'd0; wdata[r] = 32'd0; be[r] = 4'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Read held from reset release: waits out the zero-fill when it exists.
        applyStimulus(0, 1'b0, 11'h7FF, 32'd0, 4'hF, rd, ws, cs, waited);
        checkOutput("first_read_wait", waited, HAS_INIT ? 32'd2048 : 32'd0);
        checkOutput("first_read_data", rd, HAS_INIT ? 32'd0 : pat_7ff);

        applyStimulus(0, 1'b1, 11'h012, 32'hDEAD_BEEF, 4'hF, rd, ws, cs, waited);
        applyStimulus(1, 1'b0, 11'h012, 32'd0, 4'hF, rd, ws, cs, waited);
        checkOutput("raw_wait", waited, 32'd0);
        checkOutput("raw_data", rd, 32'hDEAD_BEEF);

        applyStimulus(0, 1'b1, 11'h100, 32'hFFFF_FFFF, 4'hF, rd, ws, cs, waited);
        applyStimulus(1, 1'b1, 11'h100, 32'h1122_3344, 4'b0101, rd, ws, cs, waited);
        checkOutput("partial_wen", ws, 32'hFF00_FF00);
        applyStimulus(0, 1'b0, 11'h100, 32'd0, 4'hF, rd, ws, cs, waited);
        checkOutput("partial_read", rd, 32'hFF22_FF44);

        applyStimulus(1, 1'b1, 11'h100, 32'h0000_0000, 4'b0000, rd, ws, cs, waited);
        checkOutput("be0_cen", cs, 32'd1);
        checkOutput("be0_wait", waited, 32'd0);
        applyStimulus(0, 1'b0, 11'h100, 32'd0, 4'hF, rd, ws, cs, waited);
        checkOutput("be0_read", rd, 32'hFF22_FF44);

        // Reset right after a req0 read grant: the read must not return and req0 must be favoured again.
        wr[0] = 1'b0; addr[0] = 11'h012; vld[0] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!gnt0) begin @(posedge clk); #1; end
        end while (!gnt0 && cyc < 100);
        checkOutput("rst_read_gnt", gnt0, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; vld = 2'b00;
        @(negedge clk);
        checkOutput("rst_read_rvld", rvld0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        wr = 2'b00; addr[0] = 11'h012; addr[1] = 11'h100; vld = 2'b11;
        n = 0; cyc = 0; prev = -1;
        while (n < 6 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev >= 0) checkOutput("fair_rvld", rvld_vec[prev], 32'd1);
            prev = -1;
            gseen = gnt_vec;
            if (gseen != 2'b00) begin
                checkOutput($sformatf("fair_order%0d", n), {30'd0, gseen}, (n % 2 == 0) ? 32'd1 : 32'd2);
                prev = gseen[1] ? 1 : 0;
                n++;
            end
            @(posedge clk); #1;
        end
        if (n < 6) checkOutput("fair_timeout", n, 32'd6);
        vld = 2'b00;
        @(posedge clk); #1;

        // Random traffic: requesters hold until granted, occasionally withdraw, sometimes write with no bytes enabled.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            gseen = gnt_vec;
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if ((vld[r] && gseen[r]) || !vld[r]) begin
                    vld[r]   = ($urandom_range(0, 3) != 0);
                    wr[r]    = $urandom_range(0, 1);
                    addr[r]  = 11'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 11'h7F0 : 11'h000);
                    wdata[r] = $urandom;
                    be[r]    = 4'($urandom_range(0, 15));
                end else if ($urandom_range(0, 15) == 0) begin
                    vld[r] = 1'b0;
                end
            end
        end
        vld = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
